// File: rtl/dispensador_troco.sv
// dispensador_troco
// Change dispenser for the vending machine. Takes a change amount in R$0,25
// units and ejects coins one at a time, greedy largest-first, through a
// valid/ack handshake with the coin-ejection mechanism. It aborts with an error
// pulse if the amount is out of range or the mechanism stops acknowledging.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   iniciar    start request, sampled only while idle
//   valor      change amount (R$0,25 units), sampled with iniciar
//   ack        ejector released the coin shown on moeda_out
//   moeda_out  coin to eject: 01 = R$0,25, 10 = R$0,50, 11 = R$1,00, 00 = none
//   ejeta      moeda_out valid, ejection requested
//   ocupado    high whenever not idle
//   concluido  one-cycle pulse, full amount dispensed
//   erro       one-cycle pulse, invalid valor or ack timeout
//   restante   balance still owed (R$0,25 units)
//
// state     | meaning
// ----------+------------------------------------------------------------
// OCIOSO    | idle, waiting for iniciar; restante shows last unpaid balance
// SELECIONA | one cycle: pick the largest coin that fits in restante
// EJETA     | coin presented, waiting for ack with timeout
// FIM       | concluido pulse, back to idle
// ERRO      | erro pulse, back to idle keeping the unpaid balance

module dispensador_troco #(
  parameter int MAX_VALOR      = 8,
  parameter int TIMEOUT_CICLOS = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] valor,
  input  logic       ack,
  output logic [1:0] moeda_out,
  output logic       ejeta,
  output logic       ocupado,
  output logic       concluido,
  output logic       erro,
  output logic [3:0] restante
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    SELECIONA = 3'd1,
    EJETA     = 3'd2,
    FIM       = 3'd3,
    ERRO      = 3'd4
  } estado_t;

  localparam logic [3:0] MAX_V  = 4'(MAX_VALOR);
  localparam logic [7:0] LIMITE = 8'(TIMEOUT_CICLOS - 1);

  estado_t    estado;
  logic [7:0] contador;
  logic [2:0] unidades;   // value of the coin being ejected: 1, 2 or 4

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      contador  <= '0;
      unidades  <= '0;
      moeda_out <= 2'b00;
      ejeta     <= 1'b0;
      ocupado   <= 1'b0;
      concluido <= 1'b0;
      erro      <= 1'b0;
      restante  <= '0;
    end else begin
      concluido <= 1'b0;
      erro      <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            ocupado <= 1'b1;
            if (valor > MAX_V) begin
              restante <= valor;
              erro     <= 1'b1;
              estado   <= ERRO;
            end else if (valor == 4'd0) begin
              restante  <= '0;
              concluido <= 1'b1;
              estado    <= FIM;
            end else begin
              restante <= valor;
              estado   <= SELECIONA;
            end
          end
        end

        SELECIONA: begin
          if (restante >= 4'd4) begin
            moeda_out <= 2'b11;
            unidades  <= 3'd4;
          end else if (restante >= 4'd2) begin
            moeda_out <= 2'b10;
            unidades  <= 3'd2;
          end else begin
            moeda_out <= 2'b01;
            unidades  <= 3'd1;
          end
          ejeta    <= 1'b1;
          contador <= '0;
          estado   <= EJETA;
        end

        EJETA: begin
          if (ack) begin
            // Selection guarantees unidades <= restante, so no underflow.
            restante  <= restante - {1'b0, unidades};
            ejeta     <= 1'b0;
            moeda_out <= 2'b00;
            if (restante == {1'b0, unidades}) begin
              concluido <= 1'b1;
              estado    <= FIM;
            end else begin
              estado <= SELECIONA;
            end
          end else if (contador == LIMITE) begin
            ejeta     <= 1'b0;
            moeda_out <= 2'b00;
            erro      <= 1'b1;
            estado    <= ERRO;
          end else begin
            contador <= contador + 8'd1;
          end
        end

        FIM, ERRO: begin
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end

        default: begin
          ejeta     <= 1'b0;
          moeda_out <= 2'b00;
          ocupado   <= 1'b0;
          estado    <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispensador_troco.sv
// Randomized self-checking bench for dispensador_troco. A behavioural model
// derives the greedy coin list arithmetically and, together with the ack delay
// chosen for each coin, predicts the outputs after every clock edge.

module tb_dispensador_troco;

  localparam int T    = 4;
  localparam int MAXV = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] valor;
  logic       ack;
  logic [1:0] moeda_out;
  logic       ejeta;
  logic       ocupado;
  logic       concluido;
  logic       erro;
  logic [3:0] restante;

  int n_vec = 0;
  int n_err = 0;
  int model_rest = 0;   // balance the model expects restante to show while idle

  always #5 clk = ~clk;

  dispensador_troco #(.MAX_VALOR(MAXV), .TIMEOUT_CICLOS(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .iniciar   (iniciar),
    .valor     (valor),
    .ack       (ack),
    .moeda_out (moeda_out),
    .ejeta     (ejeta),
    .ocupado   (ocupado),
    .concluido (concluido),
    .erro      (erro),
    .restante  (restante)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_out(input string tag, input int em, input int ee, input int eo,
                           input int ec, input int er, input int erest);
    check_eq({tag, ".moeda_out"}, 8'(moeda_out), 8'(em));
    check_eq({tag, ".ejeta"},     8'(ejeta),     8'(ee));
    check_eq({tag, ".ocupado"},   8'(ocupado),   8'(eo));
    check_eq({tag, ".concluido"}, 8'(concluido), 8'(ec));
    check_eq({tag, ".erro"},      8'(erro),      8'(er));
    check_eq({tag, ".restante"},  8'(restante),  8'(erest));
  endtask

  // Drive inputs for one cycle, then check the outputs after the edge.
  task automatic step(input bit a, input bit i, input int v, input int em, input int ee,
                      input int eo, input int ec, input int er, input int erest,
                      input string tag);
    ack     = a;
    iniciar = i;
    valor   = 4'(v);
    @(posedge clk);
    @(negedge clk);
    check_out(tag, em, ee, eo, ec, er, erest);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic int rv();
    return int'($urandom_range(0, 15));
  endfunction

  function automatic int code_of(input int units);
    return (units == 4) ? 3 : (units == 2) ? 2 : 1;
  endfunction

  // fixed_delay >= 0: ack comes after that many waiting cycles on every coin
  // (>= T means never); fixed_delay < 0: random delay per coin.
  task automatic run_txn(input int v, input int fixed_delay);
    int rem;
    int u;
    int d;
    if (v > MAXV) begin
      step(rb(), 1'b1, v, 0, 0, 1, 0, 1, v, "invalid");
      step(rb(), rb(), rv(), 0, 0, 0, 0, 0, v, "idle_invalid");
      model_rest = v;
      return;
    end
    if (v == 0) begin
      step(rb(), 1'b1, 0, 0, 0, 1, 1, 0, 0, "zero");
      step(rb(), rb(), rv(), 0, 0, 0, 0, 0, 0, "idle_zero");
      model_rest = 0;
      return;
    end
    step(rb(), 1'b1, v, 0, 0, 1, 0, 0, v, "start");
    rem = v;
    while (rem > 0) begin
      u = (rem >= 4) ? 4 : (rem >= 2) ? 2 : 1;
      step(rb(), rb(), rv(), code_of(u), 1, 1, 0, 0, rem, "select");
      d = (fixed_delay < 0) ? int'($urandom_range(0, T)) : fixed_delay;
      for (int k = 0; ; k++) begin
        if (k == d) begin
          rem -= u;
          if (rem == 0) step(1'b1, rb(), rv(), 0, 0, 1, 1, 0, 0, "done");
          else          step(1'b1, rb(), rv(), 0, 0, 1, 0, 0, rem, "next");
          break;
        end else if (k == T - 1) begin
          step(1'b0, rb(), rv(), 0, 0, 1, 0, 1, rem, "timeout");
          step(rb(), rb(), rv(), 0, 0, 0, 0, 0, rem, "idle_timeout");
          model_rest = rem;
          return;
        end else begin
          step(1'b0, rb(), rv(), code_of(u), 1, 1, 0, 0, rem, "wait");
        end
      end
    end
    step(rb(), rb(), rv(), 0, 0, 0, 0, 0, 0, "idle_done");
    model_rest = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++)
      step(rb(), 1'b0, rv(), 0, 0, 0, 0, 0, model_rest, "ocioso");
  endtask

  initial begin
    reset   = 1'b0;
    iniciar = 1'b0;
    ack     = 1'b0;
    valor   = '0;
    repeat (3) @(negedge clk);
    check_out("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    idle_cycles(2);

    run_txn(8, 0);       // two R$1,00 coins, ack tied high
    idle_cycles(1);
    run_txn(7, 3);       // 11, 10, 01 with three-cycle ack delay
    idle_cycles(1);
    run_txn(9, 0);       // out of range
    idle_cycles(2);      // unpaid balance held while idle
    run_txn(0, 0);
    idle_cycles(1);
    run_txn(3, T);       // ack never comes -> timeout on the 10 coin
    idle_cycles(2);
    run_txn(5, T - 1);   // ack on the last allowed cycle still succeeds

    // Asynchronous reset in the middle of an ejection.
    step(1'b0, 1'b1, 6, 0, 0, 1, 0, 0, 6, "rst_start");
    step(1'b0, 1'b0, 6, 3, 1, 1, 0, 0, 6, "rst_eject");
    #2 reset = 1'b0;
    #1 check_out("rst_async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    model_rest = 0;
    run_txn(2, 0);

    for (int n = 0; n < 80; n++) begin
      idle_cycles(int'($urandom_range(0, 2)));
      run_txn(int'($urandom_range(0, 11)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dispensador_troco.md
# dispensador_troco

Change dispenser for the vending machine: given a change amount in R$0,25 units (same 0..8 scale the coin accumulator uses for its total), it ejects coins one at a time, greedy largest-first, through a valid/ack handshake with the coin-ejection mechanism. It is the output-side counterpart of the coin accumulator, sits between the sale controller and the ejector, reuses the accumulator's coin encoding and aborts with an error if the mechanism stops acknowledging.

## Interface
- MAX_VALOR, 8: largest accepted change amount, in R$0,25 units (R$2,00).
- TIMEOUT_CICLOS, 255: maximum cycles `ejeta` is held without `ack` before abort; legal range 1..255.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start request; sampled only in OCIOSO.
- valor  in  4  change amount in R$0,25 units; sampled with `iniciar`.
- ack  in  1  ejector has released the coin presented on `moeda_out`.
- moeda_out  out  2  coin to eject: 01 = R$0,25, 10 = R$0,50, 11 = R$1,00, 00 = none.
- ejeta  out  1  `moeda_out` valid, ejection requested.
- ocupado  out  1  high in every state except OCIOSO.
- concluido  out  1  one-cycle pulse: full amount dispensed.
- erro  out  1  one-cycle pulse: invalid `valor` or ack timeout.
- restante  out  4  remaining balance still owed, in R$0,25 units.

## Operation
- All outputs registered; states: OCIOSO, SELECIONA, EJETA, FIM, ERRO.
- OCIOSO: `iniciar`=1 at an edge: `valor` > MAX_VALOR -> ERRO, `restante` <= `valor`; `valor` = 0 -> FIM; else `restante` <= `valor`, -> SELECIONA. `iniciar`=0: stay.
- SELECIONA (exactly one cycle): `restante` >= 4 -> coin 11 (4 units); >= 2 -> 10 (2 units); else 01 (1 unit). Coin latched into `moeda_out`; -> EJETA.
- EJETA: `ejeta`=1, `moeda_out` stable. `ack`=1 at an edge: `restante` -= coin value; result 0 -> FIM, else -> SELECIONA. Timeout counter (8 bits) cleared on entry, +1 per cycle without `ack`; when counter = TIMEOUT_CICLOS-1 and `ack`=0 -> ERRO, `restante` unchanged.
- FIM: `concluido`=1 for one cycle, `restante`=0, -> OCIOSO.
- ERRO: `erro`=1 for one cycle, `restante` holds unpaid balance, -> OCIOSO; `restante` keeps that value in OCIOSO until the next accepted `iniciar`.
- `iniciar` ignored outside OCIOSO; `ack` ignored outside EJETA (no effect, no error).
- `moeda_out` = 00 and `ejeta` = 0 in every state except EJETA.
- Subtraction never underflows: the selected coin is always <= `restante`.

## Timing
- Reset (`reset`=0): state OCIOSO, `moeda_out`=00, `ejeta`=0, `ocupado`=0, `concluido`=0, `erro`=0, `restante`=0, counter 0; takes effect immediately, including mid-ejection (`ejeta` drops without waiting for `ack`).
- `iniciar` at edge N -> SELECIONA in cycle N+1 -> `ejeta`=1 from edge N+2.
- `ack` high at the same edge as `ejeta` is high completes that coin; minimum 2 cycles per coin (SELECIONA + EJETA).
- After the last `ack` at edge M: `concluido`=1 during cycle M+1, `ocupado`=0 from edge M+2.
- `ack` held high continuously: every EJETA lasts exactly one cycle.
- `ejeta` high for at most TIMEOUT_CICLOS consecutive cycles; `erro` pulse in the following cycle.
- `valor`=0 or invalid: `concluido`/`erro` pulse in cycle N+1, OCIOSO at N+2, `ejeta` never asserted.

## Test plan
- `valor`=8, `ack` tied high -> two EJETA cycles with `moeda_out`=11 each, `restante` 8->4->0, `concluido` pulse at cycle 5 after `iniciar`.
- `valor`=7, `ack` delayed 3 cycles per coin -> coins 11, 10, 01 in order, `restante` 7->3->1->0, `moeda_out` stable during each wait, single `concluido`.
- `valor`=9 -> `erro` pulse, `restante`=9, `ejeta` never high; `valor`=0 -> `concluido` pulse, no ejection.
- TIMEOUT_CICLOS=4, `valor`=3, `ack` never asserted -> `ejeta` high exactly 4 cycles with `moeda_out`=10, then `erro` pulse, `restante`=3.
- `iniciar` pulsed while `ocupado`=1 and `ack` pulsed in OCIOSO/SELECIONA -> no effect on sequence or `restante`.
- `reset` asserted during EJETA of `valor`=6 -> all outputs 0 immediately; after release, `valor`=2 dispenses one coin 10 normally.
